// File: rtl/alu_frame_loader_pkg.sv
// Shared definitions for the frame loader and the ALU stage beside it:
// default word width and the loader FSM state encodings.
package alu_frame_loader_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Fixed 3-bit encodings so the ALU stage and debug tooling agree on values.
    typedef enum logic [2:0] {
        LD_SEL = 3'd0,
        LD_D0  = 3'd1,
        LD_D1  = 3'd2,
        LD_D2  = 3'd3,
        LD_D3  = 3'd4,
        EXEC   = 3'd5,
        HOLD   = 3'd6
    } state_t;

endpackage

// File: rtl/alu_frame_loader.sv
// Serial frame loader: collects an operation select plus four operands from
// a word stream, presents them to an external ALU stage, captures its two
// results and holds them until the downstream consumer takes them.
module alu_frame_loader
    import alu_frame_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [3:0]       o_sel,
    output logic [WIDTH-1:0] o_d0,
    output logic [WIDTH-1:0] o_d1,
    output logic [WIDTH-1:0] o_d2,
    output logic [WIDTH-1:0] o_d3,
    input  logic [WIDTH-1:0] i_res_0,
    input  logic [WIDTH-1:0] i_res_1,
    output logic [WIDTH-1:0] o_res_0,
    output logic [WIDTH-1:0] o_res_1,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [7:0]       o_frame_cnt
);

    state_t state;
    logic   xfer;

    assign xfer = i_valid && o_ready;

    // Loader FSM; o_ready is registered alongside the state so it is high
    // exactly in the load states.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= LD_SEL;
            o_ready     <= 1'b1;
            o_sel       <= '0;
            o_d0        <= '0;
            o_d1        <= '0;
            o_d2        <= '0;
            o_d3        <= '0;
            o_res_0     <= '0;
            o_res_1     <= '0;
            o_res_valid <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            case (state)
                LD_SEL: if (xfer) begin
                    o_sel <= i_data[3:0];
                    state <= LD_D0;
                end
                LD_D0: if (xfer) begin
                    o_d0  <= i_data;
                    state <= LD_D1;
                end
                LD_D1: if (xfer) begin
                    o_d1  <= i_data;
                    state <= LD_D2;
                end
                LD_D2: if (xfer) begin
                    o_d2  <= i_data;
                    state <= LD_D3;
                end
                LD_D3: if (xfer) begin
                    o_d3    <= i_data;
                    o_ready <= 1'b0;
                    state   <= EXEC;
                end
                EXEC: begin
                    o_res_0     <= i_res_0;
                    o_res_1     <= i_res_1;
                    o_res_valid <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: if (i_res_ready) begin
                    o_res_valid <= 1'b0;
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                    o_ready     <= 1'b1;
                    state       <= LD_SEL;
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= LD_SEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_loader.sv
// Directed bench for alu_frame_loader with a stub ALU stage
// (res0 = d0 + d1, res1 = d2 - d3) and an expected-result queue.
module tb_alu_frame_loader;

    localparam int W = 16;

    typedef struct packed {
        logic [3:0]   sel;
        logic [W-1:0] r0;
        logic [W-1:0] r1;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic [3:0]   sel;
    logic [W-1:0] d0, d1, d2, d3;
    logic [W-1:0] res_in_0, res_in_1;
    logic [W-1:0] res_0, res_1;
    logic         res_valid;
    logic         res_ready;
    logic [7:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    exp_t         sb[$];
    logic [3:0]   m_sel;
    logic [W-1:0] m_d[4];
    logic [7:0]   m_cnt;

    always #5 clk = ~clk;

    // Stub ALU stage.
    assign res_in_0 = d0 + d1;
    assign res_in_1 = d2 - d3;

    alu_frame_loader #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_valid     (valid),
        .o_ready     (ready),
        .o_sel       (sel),
        .o_d0        (d0),
        .o_d1        (d1),
        .o_d2        (d2),
        .o_d3        (d3),
        .i_res_0     (res_in_0),
        .i_res_1     (res_in_1),
        .o_res_0     (res_0),
        .o_res_1     (res_1),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_frame_cnt (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfer one word; waits (bounded) for o_ready. idx: 0 = select, 1..4 = d0..d3.
    task automatic send(input logic [W-1:0] w, input int idx);
        int n = 0;
        while (!ready && n < 50) begin
            step();
            n++;
        end
        check("ready_wait", ready, 1'b1);
        valid = 1'b1;
        data  = w;
        step();
        valid = 1'b0;
        data  = W'($urandom);
        if (idx == 0) m_sel = w[3:0];
        else m_d[idx-1] = w;
        if (idx == 4) sb.push_back('{sel: m_sel, r0: m_d[0] + m_d[1], r1: m_d[2] - m_d[3]});
    endtask

    task automatic send_frame(input logic [W-1:0] s, a, b, c, d, input bit gaps);
        logic [W-1:0] w[5];
        w[0] = s; w[1] = a; w[2] = b; w[3] = c; w[4] = d;
        for (int i = 0; i < 5; i++) begin
            send(w[i], i);
            if (gaps && i < 4) begin
                step();
                check("gap_ready", ready, 1'b1);
            end
        end
    endtask

    // Wait for results, compare against queue head; consume if res_ready is set.
    task automatic collect();
        exp_t e;
        int   n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        check("res_valid_wait", res_valid, 1'b1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("sel", sel, e.sel);
            check("res_0", res_0, e.r0);
            check("res_1", res_1, e.r1);
        end
        if (res_ready) begin
            step();
            m_cnt = m_cnt + 8'd1;
            check("res_valid_drop", res_valid, 1'b0);
            check("frame_cnt", frame_cnt, m_cnt);
            check("ready_after", ready, 1'b1);
        end
    endtask

    task automatic model_reset();
        m_sel = '0;
        for (int i = 0; i < 4; i++) m_d[i] = '0;
        m_cnt = '0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, sel, 4'h0);
        check({tag, "_d0"}, d0, '0);
        check({tag, "_d1"}, d1, '0);
        check({tag, "_d2"}, d2, '0);
        check({tag, "_d3"}, d3, '0);
        check({tag, "_res0"}, res_0, '0);
        check({tag, "_res1"}, res_1, '0);
        check({tag, "_resv"}, res_valid, 1'b0);
        check({tag, "_cnt"}, frame_cnt, 8'h00);
        check({tag, "_ready"}, ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] h0, h1;
        rst = 1'b1; valid = 1'b0; data = '0; res_ready = 1'b1;
        model_reset();
        step(); step();
        rst = 1'b0;
        check_all_zero("reset");

        // Back-to-back frame.
        send_frame(16'h0001, 16'h0005, 16'h0003, 16'h0010, 16'h0004, 1'b0);
        check("exec_ready", ready, 1'b0);
        check("exec_resv", res_valid, 1'b0);
        collect();
        check("fixed_res0", res_0, 16'h0008);
        check("fixed_res1", res_1, 16'h000C);

        // Same frame with idle cycles between words.
        send_frame(16'h0001, 16'h0005, 16'h0003, 16'h0010, 16'h0004, 1'b1);
        collect();

        // Backpressure for 10 cycles while junk words are offered.
        res_ready = 1'b0;
        send_frame(16'h0003, 16'h1111, 16'h2222, 16'h0100, 16'h0001, 1'b0);
        collect();
        h0 = res_0; h1 = res_1;
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = W'($urandom);
            step();
            check("bp_resv", res_valid, 1'b1);
            check("bp_ready", ready, 1'b0);
            check("bp_res0", res_0, h0);
            check("bp_res1", res_1, h1);
            check("bp_d3", d3, 16'h0001);
            check("bp_sel", sel, 4'h3);
        end
        valid = 1'b0;
        res_ready = 1'b1;
        step();
        m_cnt = m_cnt + 8'd1;
        check("bp_release_resv", res_valid, 1'b0);
        check("bp_release_cnt", frame_cnt, m_cnt);

        // Reset after the d1 transfer, with a word offered during reset.
        send(16'h0009, 0);
        send(16'h0A0A, 1);
        send(16'h0B0B, 2);
        rst = 1'b1; valid = 1'b1; data = 16'h1234;
        step();
        rst = 1'b0; valid = 1'b0;
        model_reset();
        check_all_zero("midrst");
        send(16'h00F2, 0);
        check("post_rst_sel", sel, 4'h2);
        send(16'h0007, 1);
        check("post_rst_d0", d0, 16'h0007);
        check("post_rst_d1_kept", d1, 16'h0000);
        send(16'h0009, 2);
        send(16'h0030, 3);
        send(16'h0011, 4);
        collect();

        // Select masking, then run until the frame counter wraps to zero.
        send_frame(16'hABC7, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
        check("mask_sel", sel, 4'h7);
        collect();
        while (m_cnt != 8'd0) begin
            send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
            collect();
        end
        check("wrap_cnt", frame_cnt, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_frame_loader.md
ALU_FRAME_LOADER -- requirements
Module: alu_frame_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result word width.
REQ-002 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_data  input  WIDTH  serial command/operand word.
REQ-005 SHALL have i_valid  input  1  i_data valid.
REQ-006 SHALL have o_ready  output  1  loader accepts a word this cycle.
REQ-007 SHALL have o_sel  output  4  registered operation select to the ALU stage.
REQ-008 SHALL have o_d0, o_d1, o_d2, o_d3  output  WIDTH each  registered operands to the ALU stage.
REQ-009 SHALL have i_res_0, i_res_1  input  WIDTH each  combinational results returned by the ALU stage.
REQ-010 SHALL have o_res_0, o_res_1  output  WIDTH each  captured results.
REQ-011 SHALL have o_res_valid  output  1  captured results valid.
REQ-012 SHALL have i_res_ready  input  1  downstream consumes results.
REQ-013 SHALL have o_frame_cnt  output  8  count of completed (consumed) frames.

Function
REQ-014 SHALL accept a word only on a cycle where i_valid and o_ready are both 1 (transfer).
REQ-015 SHALL implement FSM states LD_SEL, LD_D0, LD_D1, LD_D2, LD_D3, EXEC, HOLD.
REQ-016 SHALL hold o_ready=1 in LD_SEL..LD_D3 and 0 in EXEC and HOLD.
REQ-017 SHALL advance LD_SEL->LD_D0->LD_D1->LD_D2->LD_D3->EXEC, one state per transfer; no transfer means no state change.
REQ-018 SHALL load o_sel from i_data[3:0] on the LD_SEL transfer and ignore i_data[WIDTH-1:4].
REQ-019 SHALL load o_dN from i_data on the LD_DN transfer; unloaded registers keep their previous value.
REQ-020 SHALL, in EXEC (exactly one cycle), capture i_res_0/i_res_1 into o_res_0/o_res_1, set o_res_valid=1 and go to HOLD.
REQ-021 SHALL give latency of one edge: LD_D3 transfer at edge N, o_res_valid=1 after edge N+1.
REQ-022 SHALL keep o_sel, o_d0..o_d3, o_res_0, o_res_1 stable from EXEC through HOLD.
REQ-023 SHALL, in HOLD with i_res_ready=1, clear o_res_valid, increment o_frame_cnt and return to LD_SEL on the same edge.
REQ-024 SHALL keep o_res_valid=1 and remain in HOLD while i_res_ready=0, however long that lasts.
REQ-025 SHALL wrap o_frame_cnt modulo 256 (255 -> 0).
REQ-026 SHALL ignore i_res_ready outside HOLD and ignore i_data/i_valid when o_ready=0.

Reset
REQ-027 SHALL on i_rst=1 at a clock edge enter LD_SEL and clear o_sel, o_d0..o_d3, o_res_0, o_res_1, o_res_valid and o_frame_cnt to 0.
REQ-028 SHALL let reset take priority over a simultaneous transfer or result handshake.
REQ-029 SHALL discard a partially loaded frame or un-consumed result when reset is asserted mid-operation.
REQ-030 SHALL drive o_ready=1 in the first cycle after reset deasserts.

Structure
REQ-031 SHALL keep the FSM state encodings (3-bit localparams) and the default WIDTH in a shared package/include file used with the ALU stage.
REQ-032 SHALL be a single module with no sub-modules; the ALU stage is instantiated beside it at the top level, with o_sel/o_dN driving its select and operand inputs and its two outputs driving i_res_0/i_res_1.

Verification (bench stub: i_res_0 = o_d0 + o_d1, i_res_1 = o_d2 - o_d3)
REQ-033 SHALL cover back-to-back frame: words 0x0001, 0x0005, 0x0003, 0x0010, 0x0004 with i_res_ready=1 -> o_sel=1, o_res_0=0x0008, o_res_1=0x000C, o_res_valid high one cycle, o_frame_cnt=1.
REQ-034 SHALL cover i_valid gaps: same frame with i_valid low every other cycle -> identical results; state holds on idle cycles.
REQ-035 SHALL cover backpressure: i_res_ready=0 for 10 cycles -> o_res_valid stays 1, o_ready=0, extra i_valid words not accepted; outputs unchanged.
REQ-036 SHALL cover reset mid-frame: i_rst after LD_D1 transfer -> all outputs 0, next word 0x00F2 loads o_sel=2.
REQ-037 SHALL cover sel masking and counter wrap: first word 0xABC7 -> o_sel=7; 256 completed frames -> o_frame_cnt returns to 0.
